// File: rtl/core_writeback_if.sv
// Retire-side bundle of core_writeback: EX handoff, load read-data return,
// both forward ports and the regfile write port.
interface core_writeback_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  logic             i_ex_valid;
  logic             o_ex_ready;
  logic             i_ex_wreg;
  logic [REG_W-1:0] i_ex_rd;
  logic [XLEN-1:0]  i_ex_result;
  logic             i_ex_load;
  logic [2:0]       i_ex_funct3;
  logic [1:0]       i_ex_addr_lo;

  logic             i_bus_rvalid;
  logic [XLEN-1:0]  i_bus_rdata;

  logic             o_fwd1_en;
  logic [REG_W-1:0] o_fwd1_addr;
  logic [XLEN-1:0]  o_fwd1_data;
  logic             o_fwd2_en;
  logic [REG_W-1:0] o_fwd2_addr;
  logic [XLEN-1:0]  o_fwd2_data;

  logic             o_we;
  logic [REG_W-1:0] o_waddr;
  logic [XLEN-1:0]  o_wdata;
  logic             o_load_err;

  modport slave (
    input  i_ex_valid, i_ex_wreg, i_ex_rd, i_ex_result, i_ex_load,
           i_ex_funct3, i_ex_addr_lo, i_bus_rvalid, i_bus_rdata,
    output o_ex_ready, o_fwd1_en, o_fwd1_addr, o_fwd1_data,
           o_fwd2_en, o_fwd2_addr, o_fwd2_data,
           o_we, o_waddr, o_wdata, o_load_err
  );

  modport master (
    output i_ex_valid, i_ex_wreg, i_ex_rd, i_ex_result, i_ex_load,
           i_ex_funct3, i_ex_addr_lo, i_bus_rvalid, i_bus_rdata,
    input  o_ex_ready, o_fwd1_en, o_fwd1_addr, o_fwd1_data,
           o_fwd2_en, o_fwd2_addr, o_fwd2_data,
           o_we, o_waddr, o_wdata, o_load_err
  );
endinterface

// File: rtl/core_writeback.sv
// Integer regfile producer: M-stage holding register with load wait/timeout,
// load data alignment, two forward ports and a registered W-stage write.
module core_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 0
) (
  input logic             clk,
  input logic             rstn,
  core_writeback_if.slave wb
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (LOAD_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ALU    = 2'd1,
    S_LDWAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             m_wreg_q;
  logic [REG_W-1:0] m_rd_q;
  logic [XLEN-1:0]  m_result_q;
  logic [2:0]       m_funct3_q;
  logic [1:0]       m_addr_lo_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_we_q, w_we_d;
  logic [REG_W-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0]  w_data_q, w_data_d;
  logic             w_err_q, w_err_d;

  logic             ex_ready_c;
  logic             accept_c;
  logic             timeout_c;
  logic             leave_c;
  logic             m_writes_c;
  logic [XLEN-1:0]  load_data_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  assign m_writes_c = m_wreg_q && (m_rd_q != '0);
  assign timeout_c  = TIMEOUT_EN && (state_q == S_LDWAIT) && !wb.i_bus_rvalid
                      && (cnt_q == CNT_LAST);
  assign leave_c    = wb.i_bus_rvalid || timeout_c;
  assign accept_c   = wb.i_ex_valid && ex_ready_c;

  // Load alignment; addr_lo[0] is don't-care for halfwords.
  always_comb begin
    byte_c = wb.i_bus_rdata[{m_addr_lo_q, 3'b000} +: 8];
    half_c = m_addr_lo_q[1] ? wb.i_bus_rdata[31:16] : wb.i_bus_rdata[15:0];
    case (m_funct3_q)
      3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_data_c = {24'd0, byte_c};
      3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_data_c = {16'd0, half_c};
      default: load_data_c = wb.i_bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_EMPTY;
    if ((state_q == S_LDWAIT) && !leave_c) begin
      state_d = S_LDWAIT;
    end else if (accept_c) begin
      state_d = wb.i_ex_load ? S_LDWAIT : S_ALU;
    end
  end

  // Stall, forwarding and W-stage next values derived from the M state.
  always_comb begin
    ex_ready_c      = 1'b1;
    wb.o_fwd1_en    = 1'b0;
    wb.o_fwd1_addr  = '0;
    wb.o_fwd1_data  = '0;
    wb.o_fwd2_en    = 1'b0;
    wb.o_fwd2_addr  = '0;
    wb.o_fwd2_data  = '0;
    w_we_d          = 1'b0;
    w_err_d         = 1'b0;
    w_addr_d        = w_addr_q;
    w_data_d        = w_data_q;
    cnt_d           = '0;
    case (state_q)
      S_ALU: begin
        if (m_writes_c) begin
          wb.o_fwd1_en   = 1'b1;
          wb.o_fwd1_addr = m_rd_q;
          wb.o_fwd1_data = m_result_q;
        end
        w_we_d   = m_writes_c;
        w_addr_d = m_rd_q;
        w_data_d = m_result_q;
      end
      S_LDWAIT: begin
        ex_ready_c = leave_c;
        if (wb.i_bus_rvalid) begin
          if (m_writes_c) begin
            wb.o_fwd2_en   = 1'b1;
            wb.o_fwd2_addr = m_rd_q;
            wb.o_fwd2_data = load_data_c;
          end
          w_we_d   = m_writes_c;
          w_addr_d = m_rd_q;
          w_data_d = load_data_c;
        end else if (timeout_c) begin
          w_we_d   = m_writes_c;
          w_err_d  = 1'b1;
          w_addr_d = m_rd_q;
          w_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign wb.o_ex_ready = ex_ready_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_wreg_q    <= 1'b0;
      m_rd_q      <= '0;
      m_result_q  <= '0;
      m_funct3_q  <= '0;
      m_addr_lo_q <= '0;
    end else if (accept_c) begin
      m_wreg_q    <= wb.i_ex_wreg;
      m_rd_q      <= wb.i_ex_rd;
      m_result_q  <= wb.i_ex_result;
      m_funct3_q  <= wb.i_ex_funct3;
      m_addr_lo_q <= wb.i_ex_addr_lo;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      w_we_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_err_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      w_we_q   <= w_we_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_err_q  <= w_err_d;
    end
  end

  assign wb.o_we       = w_we_q;
  assign wb.o_waddr    = w_addr_q;
  assign wb.o_wdata    = w_data_q;
  assign wb.o_load_err = w_err_q;

endmodule

// File: tb/tb_core_writeback.sv
// Directed bench for core_writeback (LOAD_TIMEOUT=8): ALU retire, load stall,
// alignment, rd=0, timeout and reset-mid-load.
module tb_core_writeback;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  core_writeback_if bus ();

  core_writeback #(.LOAD_TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_ex_valid   = 1'b0;
    bus.i_ex_wreg    = 1'b0;
    bus.i_ex_rd      = '0;
    bus.i_ex_result  = '0;
    bus.i_ex_load    = 1'b0;
    bus.i_ex_funct3  = '0;
    bus.i_ex_addr_lo = '0;
    bus.i_bus_rvalid = 1'b0;
    bus.i_bus_rdata  = '0;
  endtask

  task automatic drive_ex(input logic load, input logic [4:0] rd, input logic [31:0] res,
                          input logic [2:0] f3, input logic [1:0] a);
    bus.i_ex_valid   = 1'b1;
    bus.i_ex_wreg    = 1'b1;
    bus.i_ex_rd      = rd;
    bus.i_ex_result  = res;
    bus.i_ex_load    = load;
    bus.i_ex_funct3  = f3;
    bus.i_ex_addr_lo = a;
  endtask

  task automatic load_seq(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp);
    drive_ex(1'b1, rd, 32'h0, f3, a);
    tick();
    bus.i_ex_valid   = 1'b0;
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = rdata;
    #1;
    chk("align_fwd2_en", 32'(bus.o_fwd2_en), 32'd1);
    chk("align_fwd2_data", bus.o_fwd2_data, exp);
    tick();
    bus.i_bus_rvalid = 1'b0;
    #1;
    chk("align_we", 32'(bus.o_we), 32'd1);
    chk("align_waddr", 32'(bus.o_waddr), 32'(rd));
    chk("align_wdata", bus.o_wdata, exp);
  endtask

  initial begin
    idle();
    tick();
    tick();
    // Reset state
    chk("rst_we", 32'(bus.o_we), 32'd0);
    chk("rst_waddr", 32'(bus.o_waddr), 32'd0);
    chk("rst_wdata", bus.o_wdata, 32'd0);
    chk("rst_err", 32'(bus.o_load_err), 32'd0);
    chk("rst_ready", 32'(bus.o_ex_ready), 32'd1);
    chk("rst_fwd1", 32'(bus.o_fwd1_en), 32'd0);
    chk("rst_fwd2", 32'(bus.o_fwd2_en), 32'd0);
    rstn = 1'b1;
    tick();

    // ALU stream, with a stray rvalid in ALU state
    drive_ex(1'b0, 5'd5, 32'hDEADBEEF, 3'b000, 2'd0);
    #1;
    chk("alu_ready0", 32'(bus.o_ex_ready), 32'd1);
    tick();
    drive_ex(1'b0, 5'd6, 32'h1, 3'b000, 2'd0);
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = 32'h12345678;
    #1;
    chk("alu_fwd1_en_a", 32'(bus.o_fwd1_en), 32'd1);
    chk("alu_fwd1_addr_a", 32'(bus.o_fwd1_addr), 32'd5);
    chk("alu_fwd1_data_a", bus.o_fwd1_data, 32'hDEADBEEF);
    chk("alu_ready1", 32'(bus.o_ex_ready), 32'd1);
    chk("alu_stray_fwd2", 32'(bus.o_fwd2_en), 32'd0);
    chk("alu_we_idle", 32'(bus.o_we), 32'd0);
    tick();
    idle();
    #1;
    chk("alu_we_a", 32'(bus.o_we), 32'd1);
    chk("alu_waddr_a", 32'(bus.o_waddr), 32'd5);
    chk("alu_wdata_a", bus.o_wdata, 32'hDEADBEEF);
    chk("alu_fwd1_addr_b", 32'(bus.o_fwd1_addr), 32'd6);
    chk("alu_fwd1_data_b", bus.o_fwd1_data, 32'h1);
    tick();
    chk("alu_we_b", 32'(bus.o_we), 32'd1);
    chk("alu_waddr_b", 32'(bus.o_waddr), 32'd6);
    chk("alu_wdata_b", bus.o_wdata, 32'h1);
    chk("alu_fwd1_off", 32'(bus.o_fwd1_en), 32'd0);
    tick();
    chk("alu_we_end", 32'(bus.o_we), 32'd0);

    // LB stall: three stalled cycles then rvalid
    drive_ex(1'b1, 5'd7, 32'h0, 3'b000, 2'd3);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall_ready", 32'(bus.o_ex_ready), 32'd0);
      chk("lb_stall_we", 32'(bus.o_we), 32'd0);
      tick();
    end
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = 32'h80FF_0000;
    #1;
    chk("lb_ready", 32'(bus.o_ex_ready), 32'd1);
    chk("lb_fwd2_en", 32'(bus.o_fwd2_en), 32'd1);
    chk("lb_fwd2_addr", 32'(bus.o_fwd2_addr), 32'd7);
    chk("lb_fwd2_data", bus.o_fwd2_data, 32'hFFFFFF80);
    tick();
    idle();
    #1;
    chk("lb_we", 32'(bus.o_we), 32'd1);
    chk("lb_waddr", 32'(bus.o_waddr), 32'd7);
    chk("lb_wdata", bus.o_wdata, 32'hFFFFFF80);
    chk("lb_fwd2_off", 32'(bus.o_fwd2_en), 32'd0);

    // Alignment sweep on 0x87654321
    load_seq(3'b100, 2'd1, 5'd11, 32'h8765_4321, 32'h0000_0043);
    load_seq(3'b001, 2'd2, 5'd12, 32'h8765_4321, 32'hFFFF_8765);
    load_seq(3'b101, 2'd0, 5'd13, 32'h8765_4321, 32'h0000_4321);

    // LW whose rvalid cycle also accepts a new ALU op
    drive_ex(1'b1, 5'd14, 32'h0, 3'b010, 2'd0);
    tick();
    drive_ex(1'b0, 5'd10, 32'h77, 3'b000, 2'd0);
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = 32'h8765_4321;
    #1;
    chk("lw_ready", 32'(bus.o_ex_ready), 32'd1);
    chk("lw_fwd2_data", bus.o_fwd2_data, 32'h8765_4321);
    tick();
    idle();
    #1;
    chk("lw_we", 32'(bus.o_we), 32'd1);
    chk("lw_waddr", 32'(bus.o_waddr), 32'd14);
    chk("lw_wdata", bus.o_wdata, 32'h8765_4321);
    chk("b2b_fwd1_en", 32'(bus.o_fwd1_en), 32'd1);
    chk("b2b_fwd1_data", bus.o_fwd1_data, 32'h77);
    tick();
    chk("b2b_waddr", 32'(bus.o_waddr), 32'd10);
    chk("b2b_wdata", bus.o_wdata, 32'h77);

    // rd=0 retires silently and does not block the next op
    drive_ex(1'b0, 5'd0, 32'h55, 3'b000, 2'd0);
    tick();
    drive_ex(1'b0, 5'd3, 32'h33, 3'b000, 2'd0);
    #1;
    chk("rd0_fwd1_en", 32'(bus.o_fwd1_en), 32'd0);
    chk("rd0_ready", 32'(bus.o_ex_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("rd0_we", 32'(bus.o_we), 32'd0);
    chk("rd0_next_fwd1_addr", 32'(bus.o_fwd1_addr), 32'd3);
    tick();
    chk("rd0_next_we", 32'(bus.o_we), 32'd1);
    chk("rd0_next_waddr", 32'(bus.o_waddr), 32'd3);

    // Timeout: eighth LDWAIT cycle fires
    drive_ex(1'b1, 5'd9, 32'h0, 3'b010, 2'd0);
    tick();
    idle();
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("to_ready", 32'(bus.o_ex_ready), (i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    chk("to_we", 32'(bus.o_we), 32'd1);
    chk("to_waddr", 32'(bus.o_waddr), 32'd9);
    chk("to_wdata", bus.o_wdata, 32'd0);
    chk("to_err", 32'(bus.o_load_err), 32'd1);
    tick();
    chk("to_err_pulse", 32'(bus.o_load_err), 32'd0);
    chk("to_we_pulse", 32'(bus.o_we), 32'd0);
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = 32'h1234_5678;
    #1;
    chk("to_stray_fwd2", 32'(bus.o_fwd2_en), 32'd0);
    tick();
    bus.i_bus_rvalid = 1'b0;
    chk("to_stray_we", 32'(bus.o_we), 32'd0);

    // Reset while a load is outstanding
    drive_ex(1'b1, 5'd8, 32'h0, 3'b010, 2'd0);
    tick();
    idle();
    #1;
    chk("mid_ready_stall", 32'(bus.o_ex_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_waddr", 32'(bus.o_waddr), 32'd0);
    chk("mid_rst_we", 32'(bus.o_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_ex_ready), 32'd1);
    tick();
    rstn = 1'b1;
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata  = 32'h1234_5678;
    #1;
    chk("mid_late_fwd2", 32'(bus.o_fwd2_en), 32'd0);
    tick();
    idle();
    chk("mid_late_we", 32'(bus.o_we), 32'd0);
    chk("mid_late_wdata", bus.o_wdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
